ysyx_25020047_mdu: RTL and testbench

Iterative RV32M multiply/divide unit; the multi-cycle companion to the single-cycle execute stage, generalised to XLEN. Accepts one M-extension operation per transaction over a valid/ready handshake, computes it with a radix-2 shift-add multiplier or a restoring divider, and holds the result until the consumer takes it. The execute stage stalls on `in_ready`/`out_valid`.

---
 rtl/ysyx_25020047_mdu_pkg.sv | 19 +
 rtl/ysyx_25020047_mdu_if.sv | 14 +
 rtl/ysyx_25020047_mdu_div.sv | 33 +++
 rtl/ysyx_25020047_mdu.sv | 123 ++++++++++++
 tb/tb_ysyx_25020047_mdu.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/ysyx_25020047_mdu_pkg.sv
// ysyx_25020047_mdu_pkg: op encodings, FSM states and operand-class helpers for the multiply/divide unit
package ysyx_25020047_mdu_pkg;
  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction
  function automatic logic is_signed(input logic [2:0] op, input logic rs2);
    return rs2 ? !(op inside {MDU_MULHSU, MDU_MULHU, MDU_DIVU, MDU_REMU})
               : !(op inside {MDU_MULHU, MDU_DIVU, MDU_REMU});
  endfunction
endpackage

// File: rtl/ysyx_25020047_mdu_if.sv
// ysyx_25020047_mdu_if: request/response handshake bundle between execute stage (master) and MDU (slave)
interface ysyx_25020047_mdu_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  modport master (output flush, in_valid, op, src1, src2, out_ready, input in_ready, out_valid, result);
  modport slave  (input flush, in_valid, op, src1, src2, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/ysyx_25020047_mdu_div.sv
// ysyx_25020047_mdu_div: restoring divider datapath on magnitudes, start loads operands, step does one subtract-shift
module ysyx_25020047_mdu_div #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] q_nxt,
  output logic [XLEN-1:0] r_nxt
);
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [XLEN:0] sh, diff;
  always_comb begin
    sh = {rem_q, quo_q[XLEN-1]};
    diff = sh - {1'b0, dvs_q};
    r_nxt = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
    q_nxt = {quo_q[XLEN-2:0], ~diff[XLEN]};
    rem_d = start ? '0 : step ? r_nxt : rem_q;
    quo_d = start ? dividend : step ? q_nxt : quo_q;
    dvs_d = start ? divisor : dvs_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
endmodule

// File: rtl/ysyx_25020047_mdu.sv
// ysyx_25020047_mdu: iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider); YSYX_25020047_MDU_FAST_MUL_EN selects a single-cycle multiplier
module ysyx_25020047_mdu
  import ysyx_25020047_mdu_pkg::*;
#(parameter int XLEN = 32) (
  input logic clk,
  input logic rst,
  ysyx_25020047_mdu_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic neg_q, neg_d, rneg_q, rneg_d, out_valid_q, out_valid_d;
  logic [XLEN-1:0] mcand_q, mcand_d, result_q, result_d;
  logic [2*XLEN-1:0] prod_q, prod_d, prod_nxt;
  logic [XLEN:0] acc;
  logic s1n, s2n, accept, dzero, ovf;
  logic [XLEN-1:0] m1, m2, q_nxt, r_nxt, q_fin, r_fin, spec_res;
  function automatic logic [XLEN-1:0] mul_res(input logic [2:0] o, input logic [2*XLEN-1:0] p, input logic n);
    logic [2*XLEN-1:0] s;
    s = n ? -p : p;
    return o == MDU_MUL ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction
  assign bus.in_ready = state_q == S_IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.result = result_q;
  ysyx_25020047_mdu_div #(.XLEN(XLEN)) u_div (
    .clk(clk),
    .rst(rst),
    .start(accept),
    .step(state_q == S_CALC),
    .dividend(m1),
    .divisor(m2),
    .q_nxt(q_nxt),
    .r_nxt(r_nxt)
  );
  always_comb begin
    s1n = is_signed(bus.op, 1'b0) && bus.src1[XLEN-1];
    s2n = is_signed(bus.op, 1'b1) && bus.src2[XLEN-1];
    m1 = s1n ? -bus.src1 : bus.src1;
    m2 = s2n ? -bus.src2 : bus.src2;
    accept = bus.in_valid && state_q == S_IDLE && !bus.flush;
    dzero = bus.src2 == '0;
    ovf = is_signed(bus.op, 1'b0) && bus.src1 == {1'b1, {(XLEN-1){1'b0}}} && bus.src2 == '1;
    spec_res = dzero ? (bus.op[1] ? bus.src1 : '1) : (bus.op[1] ? '0 : bus.src1);
    acc = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, prod_q[0] ? mcand_q : '0};
    prod_nxt = {acc, prod_q[XLEN-1:1]};
    q_fin = neg_q ? -q_nxt : q_nxt;
    r_fin = rneg_q ? -r_nxt : r_nxt;
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    mcand_d = mcand_q;
    prod_d = prod_q;
    result_d = result_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      op_d = bus.op;
      neg_d = s1n ^ s2n;
      rneg_d = s1n;
      mcand_d = m1;
      prod_d = {{XLEN{1'b0}}, m2};
      if (is_div(bus.op) && (dzero || ovf)) begin
        state_d = S_DONE;
        out_valid_d = 1'b1;
        result_d = spec_res;
      end
`ifdef YSYX_25020047_MDU_FAST_MUL_EN
      else if (!is_div(bus.op)) begin
        state_d = S_DONE;
        out_valid_d = 1'b1;
        result_d = mul_res(bus.op, {{XLEN{1'b0}}, m1} * {{XLEN{1'b0}}, m2}, s1n ^ s2n);
      end
`endif
      else begin
        state_d = S_CALC;
        cnt_d = CW'(XLEN - 1);
      end
    end
    if (state_q == S_CALC) begin
      prod_d = prod_nxt;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = S_DONE;
        cnt_d = '0;
        out_valid_d = 1'b1;
        result_d = is_div(op_q) ? (op_q[1] ? r_fin : q_fin) : mul_res(op_q, prod_nxt, neg_q);
      end
    end
    if (state_q == S_DONE && bus.out_ready) begin
      state_d = S_IDLE;
      out_valid_d = 1'b0;
    end
    if (bus.flush) begin
      state_d = S_IDLE;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      mcand_q <= '0;
      prod_q <= '0;
      result_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      mcand_q <= mcand_d;
      prod_q <= prod_d;
      result_q <= result_d;
      out_valid_q <= out_valid_d;
    end
endmodule

// File: tb/tb_ysyx_25020047_mdu.sv
// tb_ysyx_25020047_mdu: directed self-checking bench for the multiply/divide unit
module tb_ysyx_25020047_mdu;
  import ysyx_25020047_mdu_pkg::*;
`ifdef YSYX_25020047_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  ysyx_25020047_mdu_if #(.XLEN(32)) bus();
  ysyx_25020047_mdu #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, expv);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] expv, input int lat, input int hold);
    int n;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.src1 = a;
    bus.src2 = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom);
    bus.src1 = $urandom;
    bus.src2 = $urandom;
    n = 1;
    while (!bus.out_valid && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_result"}, bus.result, expv);
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
      check({tag, "_hold_result"}, bus.result, expv);
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_consumed_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_consumed_in_ready"}, 32'(bus.in_ready), 1);
  endtask
  initial begin
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.src1 = '0;
    bus.src2 = '0;
    rst = 1'b1;
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 0);
    check("reset_result", bus.result, 0);
    check("reset_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.op = MDU_DIV;
    bus.src1 = 32'd5;
    bus.src2 = 32'd0;
    @(posedge clk); #1;
    check("reset_ignores_req_valid", 32'(bus.out_valid), 0);
    check("reset_ignores_req_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    run("mul", MDU_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, 0);
    run("mulh", MDU_MULH, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 0);
    run("mulhu", MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 0);
    run("mulhsu", MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 0);
    run("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_LAT, 0);
    run("rem_neg", MDU_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, DIV_LAT, 0);
    run("div_negdivisor", MDU_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT, 0);
    run("rem_negdivisor", MDU_REM, 32'd7, 32'hFFFFFFFE, 32'd1, DIV_LAT, 0);
    run("divu", MDU_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, 0);
    run("remu", MDU_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT, 0);
    run("divu_max", MDU_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, DIV_LAT, 0);
    run("div_by_zero", MDU_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
    run("rem_by_zero", MDU_REM, 32'd5, 32'd0, 32'd5, 1, 0);
    run("remu_by_zero", MDU_REMU, 32'd7, 32'd0, 32'd7, 1, 0);
    run("div_overflow", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    run("rem_overflow", MDU_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 0);
    run("hold_mul", MDU_MUL, 32'd3, 32'd5, 32'd15, MUL_LAT, 5);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.op = MDU_DIVU;
    bus.src1 = 32'd5;
    bus.src2 = 32'd0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_drops_accept_ready", 32'(bus.in_ready), 1);
    check("flush_drops_accept_valid", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b1;
    bus.op = MDU_DIVU;
    bus.src1 = 32'd100;
    bus.src2 = 32'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("flush_div_busy", 32'(bus.in_ready), 0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_mid_div_valid", 32'(bus.out_valid), 0);
    check("flush_mid_div_ready", 32'(bus.in_ready), 1);
    run("after_flush", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, DIV_LAT, 0);
    bus.in_valid = 1'b1;
    bus.op = MDU_DIVU;
    bus.src1 = 32'd100;
    bus.src2 = 32'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 32'(bus.in_ready), 0);
    check("pre_rst_result", bus.result, 32'hFFFFFFFD);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run("post_rst", MDU_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
